// File: rtl/axis_usb_fifo_responder.sv
// Device-side model of a synchronous 8-bit USB FIFO bridge: AXI-Stream source -> usb_data (RX),
// usb_data -> AXI-Stream sink with tlast packetisation (TX). Optional flag stalls: USB_RESPONDER_STALL_EN.
`default_nettype none

module axis_usb_fifo_responder #(
  parameter int RX_DEPTH = 1024,
  parameter int TX_DEPTH = 1024,
  parameter int PKT_SIZE = 512
) (
  input  logic       aclk,
  input  logic       aresetn,
  output logic       usb_full,
  output logic       usb_empty,
  input  logic       usb_rdn,
  input  logic       usb_wrn,
  input  logic       usb_oen,
  input  logic       usb_siwun,
  inout  wire  [7:0] usb_data,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       err_contention
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int CNT_W = $clog2(PKT_SIZE);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW+1:0] TX_FULL_OCC = (TX_AW + 2)'(TX_DEPTH);
  localparam logic [CNT_W-1:0] PKT_LAST    = CNT_W'(PKT_SIZE - 1);

  // RX path state
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RX_AW:0]   rx_count_q, rx_count_d;
  logic             tready_q, tready_d;
  logic             empty_q, empty_d;
  logic             oe_q;
  logic             rx_push, rx_pop;

  // TX path state
  logic [8:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TX_AW:0]   tx_count_q, tx_count_d;
  logic [7:0]       stg_q, stg_d;
  logic             stg_v_q, stg_v_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             full_q, full_d;
  logic             err_q;
  logic             tx_wr, tx_flush, tx_valid, tx_pop;
  logic [1:0]       n_wr;
  logic [8:0]       wr_a, wr_b;
  logic [TX_AW+1:0] tx_occ_d;
  logic             force_full, force_empty;

`ifdef USB_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    force_full  = (lfsr_d[1:0] == 2'b00);
    force_empty = (lfsr_d[3:2] == 2'b00);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign force_full  = 1'b0;
  assign force_empty = 1'b0;
`endif

  // ---------------- RX: s_axis -> usb_data ----------------
  assign rx_push = s_axis_tvalid & tready_q;
  assign rx_pop  = ~usb_rdn & oe_q & ~empty_q;

  always_comb begin
    rx_wp_d    = rx_push ? rx_wp_q + RX_AW'(1) : rx_wp_q;
    rx_rp_d    = rx_pop  ? rx_rp_q + RX_AW'(1) : rx_rp_q;
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (RX_AW + 1)'(1);
      2'b01:   rx_count_d = rx_count_q - (RX_AW + 1)'(1);
      default: rx_count_d = rx_count_q;
    endcase
    tready_d = (rx_count_d != RX_FULL_CNT);
    empty_d  = (rx_count_d == '0) | force_empty;
  end

  always_ff @(posedge aclk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= s_axis_tdata;
  end

  assign usb_data      = oe_q ? rx_mem_q[rx_rp_q] : 8'hzz;
  assign s_axis_tready = tready_q;
  assign usb_empty     = empty_q;

  // ---------------- TX: usb_data -> m_axis ----------------
  // The last accepted byte is held back so a later flush can still mark it tlast.
  assign tx_wr    = ~usb_wrn & usb_oen & ~full_q;
  assign tx_flush = ~usb_siwun;
  assign tx_valid = (tx_count_q != '0);
  assign tx_pop   = tx_valid & m_axis_tready;

  always_comb begin
    n_wr      = 2'd0;
    wr_a      = 9'd0;
    wr_b      = 9'd0;
    stg_d     = stg_q;
    stg_v_d   = stg_v_q;
    pkt_cnt_d = pkt_cnt_q;
    if (tx_wr) begin
      if (stg_v_q) begin
        wr_a = {1'b0, stg_q};
        n_wr = 2'd1;
      end
      if ((pkt_cnt_q == PKT_LAST) || tx_flush) begin
        if (stg_v_q) wr_b = {1'b1, usb_data};
        else         wr_a = {1'b1, usb_data};
        n_wr      = stg_v_q ? 2'd2 : 2'd1;
        stg_v_d   = 1'b0;
        pkt_cnt_d = '0;
      end else begin
        stg_d     = usb_data;
        stg_v_d   = 1'b1;
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end else if (tx_flush && stg_v_q) begin
      wr_a      = {1'b1, stg_q};
      n_wr      = 2'd1;
      stg_v_d   = 1'b0;
      pkt_cnt_d = '0;
    end
    tx_wp_d    = tx_wp_q + TX_AW'(n_wr);
    tx_rp_d    = tx_pop ? tx_rp_q + TX_AW'(1) : tx_rp_q;
    tx_count_d = tx_count_q + (TX_AW + 1)'(n_wr) - (TX_AW + 1)'(tx_pop);
    tx_occ_d   = (TX_AW + 2)'(tx_count_d) + (TX_AW + 2)'(stg_v_d);
    full_d     = (tx_occ_d >= TX_FULL_OCC) | force_full;
  end

  always_ff @(posedge aclk) begin
    if (n_wr != 2'd0) tx_mem_q[tx_wp_q] <= wr_a;
    if (n_wr == 2'd2) tx_mem_q[tx_wp_q + TX_AW'(1)] <= wr_b;
  end

  assign m_axis_tvalid  = tx_valid;
  assign m_axis_tdata   = tx_mem_q[tx_rp_q][7:0];
  assign m_axis_tlast   = tx_valid & tx_mem_q[tx_rp_q][8];
  assign usb_full       = full_q;
  assign err_contention = err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_count_q <= '0;
      tready_q   <= 1'b0;
      empty_q    <= 1'b1;
      oe_q       <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_count_q <= '0;
      stg_q      <= '0;
      stg_v_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      full_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_count_q <= rx_count_d;
      tready_q   <= tready_d;
      empty_q    <= empty_d;
      oe_q       <= ~usb_oen;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_count_q <= tx_count_d;
      stg_q      <= stg_d;
      stg_v_q    <= stg_v_d;
      pkt_cnt_q  <= pkt_cnt_d;
      full_q     <= full_d;
      err_q      <= err_q | (~usb_oen & ~usb_wrn);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_usb_fifo_responder.sv
// Directed bench for axis_usb_fifo_responder; usb_data has pull-ups so an undriven bus reads 8'hFF.
`default_nettype none

module tb_axis_usb_fifo_responder;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       usb_full, usb_empty;
  logic       usb_rdn, usb_wrn, usb_oen, usb_siwun;
  wire  [7:0] usb_data;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic       err_contention;
  logic       drv_en;
  logic [7:0] drv_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] mq[$];

  always #5 clk = ~clk;

  assign usb_data = drv_en ? drv_data : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (usb_data[i]);
  end

  axis_usb_fifo_responder dut (
    .aclk(clk), .aresetn(aresetn),
    .usb_full(usb_full), .usb_empty(usb_empty),
    .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_oen(usb_oen), .usb_siwun(usb_siwun),
    .usb_data(usb_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .err_contention(err_contention)
  );

  // Sink capture: handshake sampled mid-cycle, the pop happens on the next rising edge.
  always @(negedge clk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) mq.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    drv_en   = 1'b1;
    drv_data = d;
    usb_wrn  = 1'b0;
    tick();
    usb_wrn  = 1'b1;
    drv_en   = 1'b0;
  endtask

  task automatic pulse_siwun();
    usb_siwun = 1'b0;
    tick();
    usb_siwun = 1'b1;
  endtask

  task automatic check_packets(input string tag);
    int nl;
    nl = 0;
    foreach (mq[i]) if (mq[i][8]) nl++;
    check_eq({tag, "_count"}, mq.size(), 1024);
    check_eq({tag, "_nlast"}, nl, 2);
    if (mq.size() == 1024) begin
      check_eq({tag, "_last512"}, mq[511], {1'b1, 8'hFF});
      check_eq({tag, "_last1024"}, mq[1023], {1'b1, 8'hFF});
      check_eq({tag, "_mid"}, mq[700], {1'b0, 8'd188});
    end
  endtask

  initial begin
    aresetn = 1'b0;
    usb_rdn = 1'b1; usb_wrn = 1'b1; usb_oen = 1'b1; usb_siwun = 1'b1;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    drv_en = 1'b0; drv_data = 8'h00;

    // Reset state
    #12;
    check_eq("rst_full", usb_full, 1);
    check_eq("rst_empty", usb_empty, 1);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_err", err_contention, 0);
    check_eq("rst_bus_z", usb_data, 8'hFF);
    @(posedge clk); #1 aresetn = 1'b1;
    tick();
    check_eq("post_rst_tready", s_axis_tready, 1);
    check_eq("post_rst_full", usb_full, 0);

    // RX: push 01..04, then read with one-cycle turnaround
    for (int i = 1; i <= 4; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    check_eq("rx_not_empty", usb_empty, 0);
    check_eq("rx_bus_z_before_oe", usb_data, 8'hFF);
    usb_oen = 1'b0;
    tick();
    usb_rdn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("rx_byte%0d", i), usb_data, i);
      tick();
      check_eq($sformatf("rx_empty_after%0d", i), usb_empty, (i == 4) ? 1 : 0);
    end
    usb_rdn = 1'b0;
    tick();
    check_eq("rx_pop_while_empty", usb_empty, 1);
    usb_rdn = 1'b1; usb_oen = 1'b1;
    tick();
    check_eq("rx_bus_z_after_oe", usb_data, 8'hFF);
    tick();

    // TX: three bytes then flush
    mq.delete();
    wr_byte(8'hA0); wr_byte(8'hA1); wr_byte(8'hA2);
    pulse_siwun();
    repeat (5) tick();
    check_eq("tx3_count", mq.size(), 3);
    if (mq.size() == 3) begin
      check_eq("tx3_b0", mq[0], {1'b0, 8'hA0});
      check_eq("tx3_b1", mq[1], {1'b0, 8'hA1});
      check_eq("tx3_b2", mq[2], {1'b1, 8'hA2});
    end

    // TX: 1024 bytes, tlast on packet-size boundaries, empty flush is a no-op
    mq.delete();
    for (int i = 0; i < 1024; i++) wr_byte(8'(i));
    repeat (5) tick();
    pulse_siwun();
    repeat (5) tick();
    check_packets("pkt");

    // TX: backpressure, fill to full and drop byte 1025
    mq.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 1023; i++) wr_byte(8'(i));
    check_eq("bp_not_full_1023", usb_full, 0);
    wr_byte(8'hFF);
    check_eq("bp_full_1024", usb_full, 1);
    wr_byte(8'h5A);
    check_eq("bp_full_after_drop", usb_full, 1);
    check_eq("bp_nothing_out", mq.size(), 0);
    m_axis_tready = 1'b1;
    repeat (1100) tick();
    check_packets("bp");
    check_eq("bp_full_cleared", usb_full, 0);
    check_eq("bp_drained", m_axis_tvalid, 0);

    // Contention: oen and wrn low together
    mq.delete();
    usb_oen = 1'b0; usb_wrn = 1'b0;
    tick();
    usb_oen = 1'b1; usb_wrn = 1'b1;
    tick();
    check_eq("err_set", err_contention, 1);
    tick();
    pulse_siwun();
    repeat (4) tick();
    check_eq("err_held", err_contention, 1);
    check_eq("err_no_capture", mq.size(), 0);

    // Reset mid-read with 10 bytes buffered
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h10 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    usb_oen = 1'b0;
    tick();
    usb_rdn = 1'b0;
    tick(); tick();
    check_eq("mid_read_head", usb_data, 8'h12);
    #2 aresetn = 1'b0;
    #1;
    check_eq("arst_empty", usb_empty, 1);
    check_eq("arst_bus_z", usb_data, 8'hFF);
    check_eq("arst_err_clr", err_contention, 0);
    check_eq("arst_full", usb_full, 1);
    usb_rdn = 1'b1; usb_oen = 1'b1;
    @(posedge clk); #1 aresetn = 1'b1;
    tick(); tick();
    check_eq("arst_still_empty", usb_empty, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77;
    tick();
    s_axis_tvalid = 1'b0;
    usb_oen = 1'b0;
    tick();
    check_eq("arst_fresh_head", usb_data, 8'h77);
    usb_rdn = 1'b0;
    tick();
    check_eq("arst_fresh_popped", usb_empty, 1);
    usb_rdn = 1'b1; usb_oen = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_usb_fifo_responder.md
Name: axis_usb_fifo_responder

Overview:
- Synthesizable device-side model of the synchronous 8-bit USB FIFO bridge interface, i.e. the chip end of the FPGA USB FIFO master.
- Drives the FIFO flags, serves host-to-FPGA bytes from an AXI-Stream source, and captures FPGA-to-host bytes into an AXI-Stream sink, with packet boundaries marked by tlast.
- Used in loopback benches and in on-board self-test builds in place of the physical chip.

Parameters:
- RX_DEPTH, 1024: host-to-FPGA buffer depth in bytes (power of 2).
- TX_DEPTH, 1024: FPGA-to-host buffer depth in bytes (power of 2).
- PKT_SIZE, 512: maximum packet length in bytes; the byte that reaches it closes the packet.

Ports:
- aclk  in  1  single clock, equal to the USB FIFO clock of the master side.
- aresetn  in  1  asynchronous active-low reset.
- usb_full  out  1  TX buffer cannot accept a byte (active high).
- usb_empty  out  1  RX buffer holds no byte (active high).
- usb_rdn  in  1  read strobe, active low.
- usb_wrn  in  1  write strobe, active low.
- usb_oen  in  1  output-enable request, active low.
- usb_siwun  in  1  send-immediate / flush, active low.
- usb_data  inout  8  shared data bus.
- s_axis_tdata  in  8  bytes to present to the master.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- m_axis_tdata  out  8  bytes written by the master.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  last byte of a packet.
- err_contention  out  1  sticky: usb_oen and usb_wrn were low in the same cycle.

Behaviour:
- Reset (aresetn low, asynchronous) gives:
  - usb_full=1, usb_empty=1, usb_data high-Z, s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tlast=0, err_contention=0.
  - Both buffers, the staging register and the packet counter cleared.
  - Reset mid-transfer discards all buffered bytes.
- RX path, s_axis to usb_data:
  - FWFT buffer of RX_DEPTH entries.
  - s_axis_tready = ~rx_full; the buffer pushes on tvalid&tready.
  - usb_empty is registered and equals (rx_count_next==0), so it asserts on the same edge that pops the last byte.
  - oe_q <= ~usb_oen (registered). usb_data carries the head byte while oe_q=1, else high-Z. This gives a one-cycle turnaround.
  - Pop on a posedge when usb_rdn=0, oe_q=1 and usb_empty=0. usb_rdn low while empty or while oe_q=0 is ignored.
  - A simultaneous push and pop leaves the count unchanged.
- TX path, usb_data to m_axis:
  - A byte is accepted on a posedge when usb_wrn=0, usb_oen=1 and usb_full=0. Writes while full (including padding bytes) are dropped.
  - The buffer stores {tlast,byte}; the one-entry staging register counts toward occupancy.
  - usb_full is registered and equals (tx_occupancy_next >= TX_DEPTH).
  - Packet byte counter pkt_cnt runs 0..PKT_SIZE-1. Accepted byte number k of a packet:
    - k==PKT_SIZE: commit any staged byte with tlast=0, then commit this byte with tlast=1; pkt_cnt<=0.
    - Otherwise: commit the staged byte (if any) with tlast=0, stage the new byte, pkt_cnt++.
  - usb_siwun sampled low:
    - Staged byte present: commit it with tlast=1; pkt_cnt<=0.
    - No staged byte: no effect, zero-length packets are not produced.
  - siwun and a write in the same cycle: the write is processed first, then the flush, so the new byte gets tlast=1.
  - m_axis is FWFT from the TX buffer; pop on tvalid&tready.
- err_contention is set on any posedge with usb_oen=0 and usb_wrn=0. That write is also dropped. Only reset clears it.

Optional Feature:
- USB_RESPONDER_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle.
  - usb_full is forced to 1 when lfsr[1:0]==2'b00.
  - usb_empty is forced to 1 when lfsr[3:2]==2'b00.
  - Forced flags gate writes and pops exactly like real ones.
- Undefined: flags reflect occupancy only and the LFSR is absent.

Test Plan:
- Reset, then push 0x01..0x04 on s_axis. Master drives oen low, then rdn low from the next cycle. Expect 0x01..0x04 on usb_data in order, and usb_empty=1 on the edge that pops 0x04.
- Master writes 3 bytes 0xA0..0xA2, then pulses siwun low one cycle. Expect m_axis to emit A0, A1, A2 with tlast only on A2.
- Master writes 1024 bytes with PKT_SIZE=512. Expect tlast on bytes 512 and 1024, and no extra tlast when a later siwun finds no staged byte.
- Hold m_axis_tready=0 and write 1025 bytes. Expect usb_full=1 once occupancy reaches 1024, and byte 1025 dropped. Then release tready: 1024 bytes drain and usb_full deasserts.
- Drive oen=0 and wrn=0 together for one cycle. Expect err_contention=1 held until aresetn low, and no byte captured.
- Assert aresetn low mid-read with 10 bytes buffered. Expect immediate usb_empty=1, usb_data high-Z, and an empty buffer after release.
